addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_if.sv | 42 ++++
 rtl/addsub_arbiter_adder_subtractor.sv | 26 ++
 rtl/addsub_arbiter.sv | 90 +++++++++
 tb/tb_addsub_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle for the two-requester add/subtract arbiter.
// The slave side is the arbiter; the master side drives requests and
// consumes results.
interface addsub_arbiter_if #(
  parameter int n = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [n-1:0] req0_x;
  logic [n-1:0] req0_y;
  logic         req0_add_n;

  logic         req1_valid;
  logic         req1_ready;
  logic [n-1:0] req1_x;
  logic [n-1:0] req1_y;
  logic         req1_add_n;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [n-1:0] rsp_s;
  logic         rsp_c_out;
  logic         rsp_overflow;
  logic         rsp_id;
  logic [7:0]   op_count;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_add_n,
    input  req1_valid, req1_x, req1_y, req1_add_n,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_s, rsp_c_out, rsp_overflow, rsp_id, op_count
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_add_n,
    output req1_valid, req1_x, req1_y, req1_add_n,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_s, rsp_c_out, rsp_overflow, rsp_id, op_count
  );
endinterface

// File: rtl/addsub_arbiter_adder_subtractor.sv
// Combinational n-bit two's complement adder/subtractor.
// Subtraction is x + ~y + 1, so c_out = 1 means no borrow.
module adder_subtractor #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         overflow
);
  logic [n-1:0] y_eff;
  logic [n:0]   sum;

  // Invert y for subtract, add the operands plus the subtract carry-in,
  // and flag signed overflow when equal-sign operands give a result of the
  // other sign.
  always_comb begin
    y_eff    = y ^ {n{add_n}};
    sum      = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, add_n};
    s        = sum[n-1:0];
    c_out    = sum[n];
    overflow = (x[n-1] == y_eff[n-1]) && (sum[n-1] != x[n-1]);
  end
endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one add/subtract datapath through a round-robin
// arbiter. The result sits in a single register slot with valid/ready
// handshake, and a delivery counter tracks completed results.
module addsub_arbiter #(
  parameter int n = 4
) (
  input  logic             clk,
  input  logic             rst,
  addsub_arbiter_if.slave  bus
);
  logic         last_grant;
  logic         slot_free;
  logic         grant0;
  logic         grant1;
  logic         accept;
  logic [n-1:0] op_x;
  logic [n-1:0] op_y;
  logic         op_add_n;
  logic [n-1:0] alu_s;
  logic         alu_c_out;
  logic         alu_overflow;

  // Grant the slot to one requester: a lone requester wins, under
  // contention the one not granted last time wins. Nothing is granted while
  // the slot still holds an undelivered result or reset is active.
  always_comb begin
    slot_free      = !bus.rsp_valid || bus.rsp_ready;
    grant0         = !rst && slot_free && bus.req0_valid &&
                     (!bus.req1_valid || last_grant);
    grant1         = !rst && slot_free && bus.req1_valid &&
                     (!bus.req0_valid || !last_grant);
    accept         = grant0 || grant1;
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
  end

  // Steer the granted requester's operands into the shared datapath.
  always_comb begin
    op_x     = grant1 ? bus.req1_x     : bus.req0_x;
    op_y     = grant1 ? bus.req1_y     : bus.req0_y;
    op_add_n = grant1 ? bus.req1_add_n : bus.req0_add_n;
  end

  adder_subtractor #(.n(n)) u_alu (
    .x        (op_x),
    .y        (op_y),
    .add_n    (op_add_n),
    .s        (alu_s),
    .c_out    (alu_c_out),
    .overflow (alu_overflow)
  );

  // Remember the last accepted requester; starting at 1 lets requester 0
  // win the first contention after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= 1'b1;
    else if (accept)
      last_grant <= grant1;
  end

  // Result slot: load on accept (even while delivering, so back-to-back
  // results flow without a bubble), drop valid on delivery with no new
  // accept, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid    <= 1'b0;
      bus.rsp_s        <= '0;
      bus.rsp_c_out    <= 1'b0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_id       <= 1'b0;
    end else if (accept) begin
      bus.rsp_valid    <= 1'b1;
      bus.rsp_s        <= alu_s;
      bus.rsp_c_out    <= alu_c_out;
      bus.rsp_overflow <= alu_overflow;
      bus.rsp_id       <= grant1;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid    <= 1'b0;
    end
  end

  // Count every delivered result, wrapping naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.op_count <= 8'd0;
    else if (bus.rsp_valid && bus.rsp_ready)
      bus.op_count <= bus.op_count + 8'd1;
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter at n = 4 with hand-computed results.
module tb_addsub_arbiter;
  logic clk;
  logic rst;
  int   check_count;
  int   pass_count;

  addsub_arbiter_if #(.n(4)) bus ();

  addsub_arbiter #(.n(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(
    input logic       v0, input logic [3:0] x0, input logic [3:0] y0, input logic a0,
    input logic       v1, input logic [3:0] x1, input logic [3:0] y1, input logic a1,
    input logic       rr
  );
    bus.req0_valid = v0;
    bus.req0_x     = x0;
    bus.req0_y     = y0;
    bus.req0_add_n = a0;
    bus.req1_valid = v1;
    bus.req1_x     = x1;
    bus.req1_y     = y1;
    bus.req1_add_n = a1;
    bus.rsp_ready  = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic [3:0] s,
                          input logic c, input logic ov, input logic id,
                          input logic [7:0] cnt);
    checkOutput({tag, ".valid"},    32'(bus.rsp_valid),    32'(v));
    checkOutput({tag, ".s"},        32'(bus.rsp_s),        32'(s));
    checkOutput({tag, ".c_out"},    32'(bus.rsp_c_out),    32'(c));
    checkOutput({tag, ".overflow"}, 32'(bus.rsp_overflow), 32'(ov));
    checkOutput({tag, ".id"},       32'(bus.rsp_id),       32'(id));
    checkOutput({tag, ".op_count"}, 32'(bus.op_count),     32'(cnt));
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    rst = 1'b1;
    applyStimulus(1, 4'd1, 4'd1, 0, 1, 4'd2, 4'd2, 0, 1);
    checkRsp("reset", 0, 4'd0, 0, 0, 0, 8'd0);
    checkOutput("reset.ready0", 32'(bus.req0_ready), 32'd0);
    checkOutput("reset.ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    tick();
    applyStimulus(0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 1);
    rst = 1'b0;
    #1;

    // Single requester 0: 3 + 4
    applyStimulus(1, 4'd3, 4'd4, 0, 0, 4'd0, 4'd0, 0, 1);
    checkOutput("t1.ready0", 32'(bus.req0_ready), 32'd1);
    checkOutput("t1.ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    checkRsp("t1", 1, 4'd7, 0, 0, 0, 8'd0);
    applyStimulus(0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 1);
    tick();
    checkRsp("t1.drain", 0, 4'd7, 0, 0, 0, 8'd1);

    // Requester 1: 7 + 1 overflows, then 5 - 3 back to back
    applyStimulus(0, 4'd0, 4'd0, 0, 1, 4'd7, 4'd1, 0, 1);
    checkOutput("t2.ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    checkRsp("t2a", 1, 4'b1000, 0, 1, 1, 8'd1);
    applyStimulus(0, 4'd0, 4'd0, 0, 1, 4'd5, 4'd3, 1, 1);
    checkOutput("t2b.ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    checkRsp("t2b", 1, 4'd2, 1, 0, 1, 8'd2);

    // Requester 0: 3 - 5 borrows, -8 - 1 overflows
    applyStimulus(1, 4'd3, 4'd5, 1, 0, 4'd0, 4'd0, 0, 1);
    tick();
    checkRsp("t3a", 1, 4'b1110, 0, 0, 0, 8'd3);
    applyStimulus(1, 4'b1000, 4'd1, 1, 0, 4'd0, 4'd0, 0, 1);
    tick();
    checkRsp("t3b", 1, 4'b0111, 1, 1, 0, 8'd4);
    applyStimulus(0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 1);
    tick();
    checkOutput("t3.drain.valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("t3.drain.op_count", 32'(bus.op_count), 32'd5);

    // Contention: last grant was 0, so 1 wins first, then alternation
    applyStimulus(1, 4'd1, 4'd1, 0, 1, 4'd2, 4'd2, 0, 1);
    checkOutput("t4.ready0", 32'(bus.req0_ready), 32'd0);
    checkOutput("t4.ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    checkRsp("t4.c1", 1, 4'd4, 0, 0, 1, 8'd5);
    tick();
    checkRsp("t4.c2", 1, 4'd2, 0, 0, 0, 8'd6);
    tick();
    checkRsp("t4.c3", 1, 4'd4, 0, 0, 1, 8'd7);
    tick();
    checkRsp("t4.c4", 1, 4'd2, 0, 0, 0, 8'd8);

    // Stall three cycles with both requesters waiting
    applyStimulus(1, 4'd1, 4'd1, 0, 1, 4'd2, 4'd2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5.stall.ready0", 32'(bus.req0_ready), 32'd0);
      checkOutput("t5.stall.ready1", 32'(bus.req1_ready), 32'd0);
      tick();
      checkRsp("t5.stall", 1, 4'd2, 0, 0, 0, 8'd8);
    end
    applyStimulus(1, 4'd1, 4'd1, 0, 1, 4'd2, 4'd2, 0, 1);
    checkOutput("t5.release.ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    checkRsp("t5.release", 1, 4'd4, 0, 0, 1, 8'd9);

    // Asynchronous reset with a result held, then contention favours 0
    rst = 1'b1;
    #1;
    checkRsp("t6.reset", 0, 4'd0, 0, 0, 0, 8'd0);
    checkOutput("t6.reset.ready0", 32'(bus.req0_ready), 32'd0);
    checkOutput("t6.reset.ready1", 32'(bus.req1_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("t6.post.ready0", 32'(bus.req0_ready), 32'd1);
    checkOutput("t6.post.ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    checkRsp("t6.post", 1, 4'd2, 0, 0, 0, 8'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
